mem_ctrl_bram: RTL and testbench

- Responder end of CpuDataInterface: implements the MemoryController modport on a single-port, word-organised on-chip RAM.
- Sits between the CPU core's data port and block RAM.
- Serves one read or write per request/acknowledge handshake, with a parameterised number of wait states.
- Serves as the default data memory for simulation and FPGA builds.

---
 rtl/mem_ctrl_pkg.sv | 19 +
 rtl/cpu_data_if.sv | 33 +++
 rtl/bram_sp.sv | 30 +++
 rtl/mem_ctrl_bram.sv | 177 +++++++++++++++++
 tb/tb_mem_ctrl_bram.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the mem_ctrl_bram data-memory controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK,
    RELEASE
  } mem_ctrl_state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } mem_op_t;

  localparam int          DATA_W          = 32;
  localparam logic [31:0] FAULT_READ_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/cpu_data_if.sv
// CPU data port. The core drives address, write data and the two asserts;
// the memory controller answers with read data and the two OK strobes.
interface CpuDataInterface;

  logic [31:0] AddressBus;
  logic [31:0] DataWriteBus;
  logic [31:0] DataReadBus;
  logic        ReadAssert;
  logic        WriteAssert;
  logic        ReadOK;
  logic        WriteOK;

  modport MemoryController (
    input  AddressBus,
    input  DataWriteBus,
    input  ReadAssert,
    input  WriteAssert,
    output DataReadBus,
    output ReadOK,
    output WriteOK
  );

  modport Cpu (
    output AddressBus,
    output DataWriteBus,
    output ReadAssert,
    output WriteAssert,
    input  DataReadBus,
    input  ReadOK,
    input  WriteOK
  );

endinterface

// File: rtl/bram_sp.sv
// Single-port synchronous RAM with registered read data, written so that
// synthesis maps it onto a block RAM. rdata only changes on an enabled read.
module bram_sp #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // One access per enabled cycle: write the word or register its contents.
  // NOTE: the array and rdata carry no reset; a reset term would stop the
  // tools from mapping this onto block RAM, and the contents must survive reset.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/mem_ctrl_bram.sv
// Responder end of CpuDataInterface: one read or write per request/acknowledge
// handshake against an on-chip word RAM, with WAIT_STATES cycles of delay.
// Optional feature: define MEMCTRL_FAULT_EN to flag accesses whose address has
// bits set above the word index (fault / fault_addr ports, 32'hDEADBEEF reads,
// writes suppressed). Without it, addresses alias modulo DEPTH words.
module mem_ctrl_bram
  import mem_ctrl_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1,
  parameter int ADDR_LSB    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  CpuDataInterface.MemoryController bus,
  output logic                      busy
`ifdef MEMCTRL_FAULT_EN
  ,
  output logic                      fault,
  output logic [31:0]               fault_addr
`endif
);

  localparam int          IDX_W     = $clog2(DEPTH);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

  mem_ctrl_state_t   state_q, state_d;
  logic [3:0]        wait_q, wait_d;

  mem_op_t           op_q, req_op, acc_op;
  logic [IDX_W-1:0]  idx_q, req_idx, acc_idx;
  logic [DATA_W-1:0] wdata_q, acc_wdata, ram_rdata;
  logic              oor_q, req_oor, acc_oor;

  logic              capture;
  logic              entering_ack;
  logic              ram_en, ram_we;
  logic              rd_valid_q, rd_oor_q;

  // Request decode: write wins when both asserts are high.
  assign req_op  = bus.WriteAssert ? OP_WRITE : OP_READ;
  assign req_idx = IDX_W'(bus.AddressBus >> ADDR_LSB);

`ifdef MEMCTRL_FAULT_EN
  assign req_oor = (bus.AddressBus >> (ADDR_LSB + IDX_W)) != '0;
`else
  assign req_oor = 1'b0;
`endif

  // Next-state logic for the handshake FSM.
  // NOTE: every signal gets its default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.WriteAssert || bus.ReadAssert) begin
          capture = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d = ACK;
          end else begin
            state_d = WAIT;
            wait_d  = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        wait_d = wait_q - 4'd1;
        if (wait_q <= 4'd1) begin
          state_d = ACK;
        end
      end
      ACK: begin
        state_d = RELEASE;
      end
      RELEASE: begin
        if (!bus.ReadAssert && !bus.WriteAssert) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // With zero wait states the capture and the RAM access share an edge, so the
  // access takes the live request instead of the not-yet-loaded capture regs.
  assign acc_op    = capture ? req_op           : op_q;
  assign acc_idx   = capture ? req_idx          : idx_q;
  assign acc_wdata = capture ? bus.DataWriteBus : wdata_q;
  assign acc_oor   = capture ? req_oor          : oor_q;

  // Reset on the edge that would enter ACK drops the pending access.
  assign entering_ack = (state_d == ACK) && !reset;
  assign ram_en       = entering_ack && !acc_oor;
  assign ram_we       = ram_en && (acc_op == OP_WRITE);

  bram_sp #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (acc_idx),
    .wdata (acc_wdata),
    .rdata (ram_rdata)
  );

  // FSM state register and wait counter.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Request capture; later changes on the bus are ignored.
  always_ff @(posedge clk) begin
    if (capture) begin
      op_q    <= req_op;
      idx_q   <= req_idx;
      wdata_q <= bus.DataWriteBus;
      oor_q   <= req_oor;
    end
  end

  // Qualifies the RAM output so DataReadBus reads 0 until the first read and
  // then holds the last completed read.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_oor_q   <= 1'b0;
    end else if (entering_ack && (acc_op == OP_READ)) begin
      rd_valid_q <= 1'b1;
      rd_oor_q   <= acc_oor;
    end
  end

  assign bus.ReadOK      = (state_q == ACK) && (op_q == OP_READ);
  assign bus.WriteOK     = (state_q == ACK) && (op_q == OP_WRITE);
  assign bus.DataReadBus = !rd_valid_q ? '0 : (rd_oor_q ? FAULT_READ_DATA : ram_rdata);
  assign busy            = (state_q != IDLE);

`ifdef MEMCTRL_FAULT_EN
  logic [31:0] addr_q, acc_addr;

  // Full request address, kept for fault reporting.
  always_ff @(posedge clk) begin
    if (capture) begin
      addr_q <= bus.AddressBus;
    end
  end

  assign acc_addr = capture ? bus.AddressBus : addr_q;

  // Latch the faulting address on the edge that enters ACK.
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_addr <= '0;
    end else if (entering_ack && acc_oor) begin
      fault_addr <= acc_addr;
    end
  end

  assign fault = (state_q == ACK) && oor_q;
`endif

endmodule

// File: tb/tb_mem_ctrl_bram.sv
// Bench for mem_ctrl_bram: two instances (1 and 0 wait states) see the same
// request stream; a cycle-numbered reference model predicts acknowledges,
// busy, read data and memory contents. MEMCTRL_FAULT_EN adds fault checks.
module tb_mem_ctrl_bram;
  import mem_ctrl_pkg::*;

  localparam int DEPTH    = 1024;
  localparam int ADDR_LSB = 2;
  localparam int IDX_W    = $clog2(DEPTH);
  localparam int WS0      = 1;
  localparam int WS1      = 0;
  localparam int WS_MAX   = 1;
  localparam int NO_DROP  = 32'h3fff_ffff;

  logic clk = 1'b0;
  logic reset;
  logic busy0, busy1;
`ifdef MEMCTRL_FAULT_EN
  logic        fault0, fault1;
  logic [31:0] fault_addr0, fault_addr1;
`endif

  CpuDataInterface bus0 ();
  CpuDataInterface bus1 ();

  always #5 clk = ~clk;

  mem_ctrl_bram #(.DEPTH(DEPTH), .WAIT_STATES(WS0), .ADDR_LSB(ADDR_LSB)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0),
    .busy  (busy0)
`ifdef MEMCTRL_FAULT_EN
    , .fault (fault0), .fault_addr (fault_addr0)
`endif
  );

  mem_ctrl_bram #(.DEPTH(DEPTH), .WAIT_STATES(WS1), .ADDR_LSB(ADDR_LSB)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1),
    .busy  (busy1)
`ifdef MEMCTRL_FAULT_EN
    , .fault (fault1), .fault_addr (fault_addr1)
`endif
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // Reference model: the request in flight, described by cycle numbers.
  // m_cap is the first cycle after the capture edge; the acknowledge falls in
  // cycle m_cap + WS; busy lasts until the later of the drop cycle and the
  // cycle after the acknowledge.
  bit          m_active = 1'b0;
  int          m_cap    = -100;
  int          m_drop   = -100;
  mem_op_t     m_op;
  int          m_idx;
  logic [31:0] m_data;
  logic [31:0] m_addr;
  bit          m_oor;

  logic [31:0] mem_m      [2][DEPTH];
  bit          mem_known  [2][DEPTH];
  logic [31:0] last_rd    [2];
  bit          last_known [2];
  logic [31:0] last_faddr [2];
  int          ok_count   [2];
  int          ok_cyc     [2];

  // compare-process temporaries
  logic        c_rok, c_wok, c_busy, c_flt;
  logic [31:0] c_rdata, c_faddr;
  int          c_okc, c_lastb;
  bit          c_eok, c_ebusy;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int ws_of(input int k);
    return (k == 0) ? WS0 : WS1;
  endfunction

  task automatic get_outs(input int k, output logic rok, output logic wok, output logic bsy,
                          output logic [31:0] rdata, output logic flt, output logic [31:0] faddr);
    flt   = 1'b0;
    faddr = '0;
    if (k == 0) begin
      rok = bus0.ReadOK; wok = bus0.WriteOK; bsy = busy0; rdata = bus0.DataReadBus;
`ifdef MEMCTRL_FAULT_EN
      flt = fault0; faddr = fault_addr0;
`endif
    end else begin
      rok = bus1.ReadOK; wok = bus1.WriteOK; bsy = busy1; rdata = bus1.DataReadBus;
`ifdef MEMCTRL_FAULT_EN
      flt = fault1; faddr = fault_addr1;
`endif
    end
  endtask

  task automatic set_bus(input logic [31:0] a, input logic [31:0] d, input logic rd, input logic wr);
    bus0.AddressBus = a; bus0.DataWriteBus = d; bus0.ReadAssert = rd; bus0.WriteAssert = wr;
    bus1.AddressBus = a; bus1.DataWriteBus = d; bus1.ReadAssert = rd; bus1.WriteAssert = wr;
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    for (int k = 0; k < 2; k++) begin
      last_rd[k]    = '0;
      last_known[k] = 1'b1;
      last_faddr[k] = '0;
    end
  endtask

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      get_outs(k, c_rok, c_wok, c_busy, c_rdata, c_flt, c_faddr);
      c_okc   = m_cap + ws_of(k);
      c_lastb = (m_drop > c_okc + 1) ? m_drop : c_okc + 1;
      c_eok   = m_active && (cyc == c_okc);
      c_ebusy = m_active && (cyc >= m_cap) && (cyc <= c_lastb);
      if (c_eok && m_op == OP_WRITE && !m_oor) begin
        mem_m[k][m_idx]     = m_data;
        mem_known[k][m_idx] = 1'b1;
      end
      if (c_eok && m_op == OP_READ) begin
        if (m_oor) begin
          last_rd[k]    = 32'hDEADBEEF;
          last_known[k] = 1'b1;
        end else begin
          last_rd[k]    = mem_m[k][m_idx];
          last_known[k] = mem_known[k][m_idx];
        end
      end
      if (c_eok && m_oor) last_faddr[k] = m_addr;
      check($sformatf("dut%0d ReadOK", k),  32'(c_rok),  32'(c_eok && m_op == OP_READ));
      check($sformatf("dut%0d WriteOK", k), 32'(c_wok),  32'(c_eok && m_op == OP_WRITE));
      check($sformatf("dut%0d busy", k),    32'(c_busy), 32'(c_ebusy));
      if (last_known[k]) check($sformatf("dut%0d DataReadBus", k), c_rdata, last_rd[k]);
`ifdef MEMCTRL_FAULT_EN
      check($sformatf("dut%0d fault", k),      32'(c_flt), 32'(c_eok && m_oor));
      check($sformatf("dut%0d fault_addr", k), c_faddr,    last_faddr[k]);
`endif
      if (c_rok || c_wok) begin
        ok_count[k]++;
        ok_cyc[k] = cyc;
      end
    end
  end

  // Drive a request and load the model; called just after a rising edge.
  task automatic start_req(input bit wr, input bit both, input logic [31:0] a, input logic [31:0] d);
    ok_count[0] = 0;
    ok_count[1] = 0;
    m_cap    = cyc + 1;
    m_drop   = NO_DROP;
    m_op     = wr ? OP_WRITE : OP_READ;
    m_idx    = int'((a >> ADDR_LSB) % DEPTH);
    m_data   = d;
    m_addr   = a;
`ifdef MEMCTRL_FAULT_EN
    m_oor    = (a >> (ADDR_LSB + IDX_W)) != 0;
`else
    m_oor    = 1'b0;
`endif
    m_active = 1'b1;
    set_bus(a, d, !wr || both, wr);
  endtask

  // Full handshake: assert, scramble the bus after capture, hold until both
  // instances are in RELEASE plus 'extra' cycles, then drop the asserts.
  task automatic do_req(input bit wr, input bit both, input logic [31:0] a,
                        input logic [31:0] d, input int extra);
    @(posedge clk); #1;
    start_req(wr, both, a, d);
    @(posedge clk); #1;
    bus0.AddressBus = $urandom; bus0.DataWriteBus = $urandom;
    bus1.AddressBus = bus0.AddressBus; bus1.DataWriteBus = bus0.DataWriteBus;
    repeat (WS_MAX + 1 + extra) begin
      @(posedge clk); #1;
    end
    set_bus($urandom, $urandom, 1'b0, 1'b0);
    m_drop = cyc;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " dut0 ReadOK"},  32'(bus0.ReadOK),  32'd0);
    check({tag, " dut0 WriteOK"}, 32'(bus0.WriteOK), 32'd0);
    check({tag, " dut0 busy"},    32'(busy0),        32'd0);
    check({tag, " dut0 data"},    bus0.DataReadBus,  32'd0);
    check({tag, " dut1 busy"},    32'(busy1),        32'd0);
    check({tag, " dut1 data"},    bus1.DataReadBus,  32'd0);
  endtask

  logic [31:0] r_addr, r_data;
  bit          r_wr, r_both;
  int          r_extra, r_gap;

  initial begin
    reset = 1'b1;
    set_bus('0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < DEPTH; i++) mem_known[k][i] = 1'b0;
      ok_count[k] = 0;
      ok_cyc[k]   = 0;
    end
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    reset = 1'b0;
    settle();
    check_reset_values("reset");

    // Write then read 0x10: ack 2 cycles (WS=1) and 1 cycle (WS=0) after capture.
    do_req(1'b1, 1'b0, 32'h10, 32'hCAFEF00D, 0);
    settle();
    check("wr 0x10 latency dut0", 32'(ok_cyc[0] - (m_cap - 1)), 32'd2);
    check("wr 0x10 latency dut1", 32'(ok_cyc[1] - (m_cap - 1)), 32'd1);
    do_req(1'b0, 1'b0, 32'h10, 32'h0, 0);
    settle();
    check("rd 0x10 data dut0", bus0.DataReadBus, 32'hCAFEF00D);
    check("rd 0x10 data dut1", bus1.DataReadBus, 32'hCAFEF00D);
    check("rd 0x10 latency dut1", 32'(ok_cyc[1] - (m_cap - 1)), 32'd1);

    // Back-to-back reads of words 0 and 1.
    do_req(1'b1, 1'b0, 32'h0, 32'h0BADF00D, 0);
    do_req(1'b1, 1'b0, 32'h4, 32'h600DCAFE, 0);
    do_req(1'b0, 1'b0, 32'h0, 32'h0, 0);
    settle();
    check("rd 0x0 data dut1", bus1.DataReadBus, 32'h0BADF00D);
    check("rd 0x0 ok count dut1", 32'(ok_count[1]), 32'd1);
    do_req(1'b0, 1'b0, 32'h4, 32'h0, 0);
    settle();
    check("rd 0x4 data dut1", bus1.DataReadBus, 32'h600DCAFE);
    check("rd 0x4 ok count dut1", 32'(ok_count[1]), 32'd1);

    // Read held for 10 cycles: a single acknowledge each.
    do_req(1'b0, 1'b0, 32'h10, 32'h0, 7);
    settle();
    check("held rd ok count dut0", 32'(ok_count[0]), 32'd1);
    check("held rd ok count dut1", 32'(ok_count[1]), 32'd1);

    // Both asserts: the write wins.
    do_req(1'b1, 1'b1, 32'h20, 32'h12345678, 0);
    do_req(1'b0, 1'b0, 32'h20, 32'h0, 0);
    settle();
    check("both-assert rd 0x20 dut0", bus0.DataReadBus, 32'h12345678);

    // Reset in the WAIT cycle of dut0's write (dut1 is already in ACK).
    do_req(1'b1, 1'b0, 32'h40, 32'h11112222, 0);
    @(posedge clk); #1;
    start_req(1'b1, 1'b0, 32'h40, 32'hAAAA5555);
    @(posedge clk); #1;
    reset = 1'b1;
    set_bus($urandom, $urandom, 1'b0, 1'b0);
    m_drop = cyc;
    @(posedge clk); #1;
    model_reset();
    reset = 1'b0;
    settle();
    check_reset_values("mid reset");
    do_req(1'b0, 1'b0, 32'h40, 32'h0, 0);
    settle();
    check("rd 0x40 after reset dut0", bus0.DataReadBus, 32'h11112222);
    check("rd 0x40 after reset dut1", bus1.DataReadBus, 32'hAAAA5555);

    // Address just past the RAM.
    do_req(1'b0, 1'b0, 32'h0000_1000, 32'h0, 0);
    settle();
`ifdef MEMCTRL_FAULT_EN
    check("rd 0x1000 data dut0", bus0.DataReadBus, 32'hDEADBEEF);
    check("rd 0x1000 fault_addr dut0", fault_addr0, 32'h0000_1000);
`else
    check("rd 0x1000 alias dut0", bus0.DataReadBus, 32'h0BADF00D);
`endif

    // Randomised traffic over a small window of words, some with high bits set.
    for (int i = 0; i < 400; i++) begin
      r_wr    = 1'($urandom_range(0, 1));
      r_both  = r_wr && ($urandom_range(0, 3) == 0);
      r_addr  = (32'($urandom_range(0, 31)) << ADDR_LSB) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) r_addr = r_addr | (32'($urandom) << (ADDR_LSB + IDX_W));
      r_data  = $urandom;
      r_extra = $urandom_range(0, 3);
      r_gap   = $urandom_range(0, 2);
      repeat (r_gap) @(posedge clk);
      do_req(r_wr, r_both, r_addr, r_data, r_extra);
    end

    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
